// File: rtl/mem_arbiter.sv
// Purpose: arbitrates the I-cache and D-cache request ports onto single-ported main memory.
// Latency: grant on the first edge, completion on ram_ready (or forced at timeout), then one idle cycle.
// Backpressure: requesters are held off by iwait/dwait until their access completes.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

    localparam logic [3:0]  STREAK_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0]  TCNT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [31:0] BAD_LOAD   = 32'hBAD0BAD0;

    state_t      state, state_n;
    logic [3:0]  dstreak;
    logic [7:0]  tcnt;
    logic        is_write;
    logic        grant_d, grant_i, in_acc, done;
    logic [31:0] result;

    // Data wins unless the instruction side has already been passed over STARVE_LIMIT times.
    assign grant_d = (dREN | dWEN) && !(iREN && dstreak == STREAK_MAX);
    assign grant_i = !grant_d && iREN;
    assign in_acc  = (state == DACC) || (state == IACC);
    // A reset cycle never releases a wait, even if RAM answers in it.
    assign done    = in_acc && !RST && (ram_ready || tcnt == TCNT_LAST);
    assign result  = ram_ready ? ram_load : BAD_LOAD;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (grant_d)
                    state_n = DACC;
                else if (grant_i)
                    state_n = IACC;
            end
            DACC, IACC: begin
                if (done)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            dstreak   <= '0;
            tcnt      <= '0;
            is_write  <= 1'b0;
            err       <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                tcnt <= '0;
                if (grant_d) begin
                    ram_addr <= daddr;
                    is_write <= dWEN;
                    if (dWEN)
                        ram_store <= dstore;
                    dstreak <= iREN ? dstreak + 4'd1 : 4'd0;
                end else if (grant_i) begin
                    ram_addr <= iaddr;
                    is_write <= 1'b0;
                    dstreak  <= '0;
                end
            end else begin
                tcnt <= tcnt + 8'd1;
            end
            if (done && !ram_ready)
                err <= 1'b1;
        end
    end

    assign iwait   = !(done && state == IACC);
    assign dwait   = !(done && state == DACC);
    assign iload   = (done && state == IACC) ? result : 32'd0;
    assign dload   = (done && state == DACC && !is_write) ? result : 32'd0;
    assign ram_ren = (state == IACC) || (state == DACC && !is_write);
    assign ram_wen = (state == DACC) && is_write;
endmodule
